// File: rtl/nubus_pkg.sv
// nubus_pkg: NuBus slave status/transfer-mode encodings, FSM states and start-cycle decode.
package nubus_pkg;
  // Status as driven on the active-low TM1/TM0 lines: {tm1_n, tm0_n}
  localparam logic [1:0] TMN_COMPLETE = 2'b11;
  localparam logic [1:0] TMN_ERROR    = 2'b10;
  // Logical ad[1:0] for tm0 = 0 starts
  localparam logic [1:0] TMADN_HALF0 = 2'b00;
  localparam logic [1:0] TMADN_BLOCK = 2'b01;
  localparam logic [1:0] TMADN_HALF1 = 2'b10;
  localparam logic [1:0] TMADN_WORD  = 2'b11;
  typedef enum logic [2:0] {IDLE, WDATA, REQ, ERR, ACK} state_t;
  typedef struct packed {
    logic       we;
    logic [3:0] be;
    logic       unsup;
  } tm_dec_t;
  function automatic tm_dec_t tm_decode(input logic tm1, input logic tm0, input logic [1:0] a);
    tm_dec_t d;
    d.we    = tm1;
    d.unsup = !tm0 && a == TMADN_BLOCK;
    d.be    = tm0 ? 4'b0001 << a :
              a == TMADN_WORD  ? 4'b1111 :
              a == TMADN_HALF0 ? 4'b0011 :
              a == TMADN_HALF1 ? 4'b1100 : 4'b0000;
    return d;
  endfunction
endpackage

// File: rtl/nubus_slave_engine.sv
// nubus_slave_engine: decodes NuBus START cycles for this slot into single local-bus
// requests and completes each one with a registered one-clock ACK carrying status/data.
module nubus_slave_engine
  import nubus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200,
  parameter int ADDR_W         = 22
) (
  input  logic              clk_3v3,
  input  logic              reset_3v3_n,
  input  logic [3:0]        id_3v3_n,
  input  logic              start_3v3_n,
  input  logic              ack_3v3_n,
  input  logic              tm0_3v3_n,
  input  logic              tm1_3v3_n,
  input  logic [31:0]       ad_3v3_n,
  output logic [31:0]       ad_o_n,
  output logic              ad_oe_n,
  output logic              ack_o_n,
  output logic              ack_oe_n,
  output logic              tm0_o_n,
  output logic              tm1_o_n,
  output logic              tmx_oe_n,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_error,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   ad;
  tm_dec_t       dec;
  logic          hit, timeout, done, ok;
  assign ad      = ~ad_3v3_n;
  assign dec     = tm_decode(!tm1_3v3_n, !tm0_3v3_n, ad[1:0]);
  // Attention cycles (START with ACK) never address a slave
  assign hit     = !start_3v3_n && ack_3v3_n && ad[31:24] == {4'hF, ~id_3v3_n};
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign done    = state == ERR || (state == REQ && (mem_ready || timeout));
  assign ok      = state == REQ && mem_ready && !mem_error;
  assign busy    = state != IDLE;
  always_ff @(posedge clk_3v3) begin
    if (!reset_3v3_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ad_o_n    <= '1;
      ad_oe_n   <= 1'b1;
      ack_o_n   <= 1'b1;
      ack_oe_n  <= 1'b1;
      tm0_o_n   <= 1'b1;
      tm1_o_n   <= 1'b1;
      tmx_oe_n  <= 1'b1;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else if (done) begin
      // A ready in the same cycle as the timeout wins through ok
      state                <= ACK;
      mem_valid            <= 1'b0;
      ack_o_n              <= 1'b0;
      ack_oe_n             <= 1'b0;
      tmx_oe_n             <= 1'b0;
      {tm1_o_n, tm0_o_n}   <= ok ? TMN_COMPLETE : TMN_ERROR;
      ad_oe_n              <= mem_we;
      ad_o_n               <= ok && !mem_we ? ~mem_rdata : '1;
    end else if (state == ACK) begin
      state    <= IDLE;
      ad_o_n   <= '1;
      ad_oe_n  <= 1'b1;
      ack_o_n  <= 1'b1;
      ack_oe_n <= 1'b1;
      tm0_o_n  <= 1'b1;
      tm1_o_n  <= 1'b1;
      tmx_oe_n <= 1'b1;
    end else if (state == IDLE && hit) begin
      state     <= dec.unsup ? ERR : dec.we ? WDATA : REQ;
      mem_valid <= !dec.unsup && !dec.we;
      mem_we    <= dec.we;
      mem_be    <= dec.be;
      mem_addr  <= ad[ADDR_W+1:2];
      cnt       <= '0;
    end else if (state == WDATA) begin
      state     <= REQ;
      mem_wdata <= ad;
      mem_valid <= 1'b1;
      cnt       <= '0;
    end else if (state == REQ) begin
      cnt <= &cnt ? cnt : cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_nubus_slave_engine.sv
// tb_nubus_slave_engine: vector table of NuBus transactions against a local memory
// model, with a request scoreboard and hand-written reset/ignore/timeout sequences.
module tb_nubus_slave_engine;
  import nubus_pkg::*;
  logic        clk = 0;
  always #5 clk = ~clk;
  logic        reset_n = 0;
  logic [3:0]  id_n = 4'h3;
  logic        start_n = 1, ack_n = 1, tm0_n = 1, tm1_n = 1;
  logic [31:0] ad_n = '1;
  logic [31:0] ad_o_n, mem_wdata;
  logic        ad_oe_n, ack_o_n, ack_oe_n, tm0_o_n, tm1_o_n, tmx_oe_n;
  logic        mem_valid, mem_we, busy;
  logic [21:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_ready = 0, mem_error = 0;
  logic [31:0] mem_rdata = 0;

  nubus_slave_engine #(.TIMEOUT_CYCLES(200), .ADDR_W(22)) dut (
    .clk_3v3(clk), .reset_3v3_n(reset_n), .id_3v3_n(id_n),
    .start_3v3_n(start_n), .ack_3v3_n(ack_n), .tm0_3v3_n(tm0_n), .tm1_3v3_n(tm1_n),
    .ad_3v3_n(ad_n), .ad_o_n(ad_o_n), .ad_oe_n(ad_oe_n), .ack_o_n(ack_o_n),
    .ack_oe_n(ack_oe_n), .tm0_o_n(tm0_o_n), .tm1_o_n(tm1_o_n), .tmx_oe_n(tmx_oe_n),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_error(mem_error),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [21:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;
  typedef struct {
    logic        wr, tm0;
    logic [31:0] a, wd;
    int          dly;
    logic        err, req;
    logic [3:0]  be;
    logic [21:0] addr;
    logic [1:0]  st;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  req_t        sb[$];
  req_t        r_sb;
  logic [31:0] model [64] = '{default: 32'h0};
  int          checks = 0, failures = 0, rdy_dly = 0, vcnt = 0;
  logic        err_flag = 0;
  vec_t        vecs [17];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Local-bus responder: checks each new request against the scoreboard, answers after rdy_dly clocks
  always @(negedge clk) begin
    if (mem_valid) begin
      if (vcnt == 0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: got addr %0h expected no request", mem_addr);
        end else begin
          r_sb = sb.pop_front();
          chk("req_we", mem_we, r_sb.we);
          chk("req_addr", mem_addr, r_sb.addr);
          chk("req_be", mem_be, r_sb.be);
          if (r_sb.we) chk("req_wdata", mem_wdata, r_sb.wd);
        end
      end
      if (rdy_dly >= 0 && vcnt >= rdy_dly) begin
        mem_ready = 1;
        mem_error = err_flag;
        mem_rdata = model[mem_addr[5:0]];
        if (mem_we && !err_flag)
          for (int i = 0; i < 4; i++)
            if (mem_be[i]) model[mem_addr[5:0]][8*i+:8] = mem_wdata[8*i+:8];
      end else mem_ready = 0;
      vcnt++;
    end else begin
      mem_ready = 0;
      vcnt = 0;
    end
  end

  task automatic check_reset(input string nm);
    chk({nm, "_ad_o_n"}, ad_o_n, 32'hFFFF_FFFF);
    chk({nm, "_ctrl"}, {ad_oe_n, ack_o_n, ack_oe_n, tm0_o_n, tm1_o_n, tmx_oe_n, mem_valid, mem_we, busy},
        9'b111111_000);
    chk({nm, "_addr_be"}, {mem_addr, mem_be}, 26'h0);
    chk({nm, "_wdata"}, mem_wdata, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int          lat = -1;
    logic [1:0]  st = 0;
    logic [31:0] rd = 0;
    logic        aoe = 0, mv = 0, ao = 1;
    rdy_dly  = v.dly;
    err_flag = v.err;
    if (v.req) sb.push_back(req_t'{v.wr, v.addr, v.be, v.wd});
    start_n = 0; tm1_n = ~v.wr; tm0_n = ~v.tm0; ad_n = ~v.a;
    @(posedge clk); @(negedge clk);
    start_n = 1; tm1_n = 1; tm0_n = 1; ad_n = v.wr ? ~v.wd : '1;
    for (int k = 1; k <= 300 && lat < 0; k++) begin
      @(posedge clk); @(negedge clk);
      ad_n = '1;
      if (!ack_oe_n) begin
        lat = k + 1; st = {tm1_o_n, tm0_o_n}; rd = ~ad_o_n;
        aoe = ad_oe_n; mv = mem_valid; ao = ack_o_n;
      end
    end
    chk({nm, "_ack_edge"}, lat, v.lat);
    if (lat >= 0) begin
      chk({nm, "_status"}, st, v.st);
      chk({nm, "_ack_val"}, {ao, tmx_oe_n}, 2'b00);
      chk({nm, "_ad_oe"}, aoe, v.wr);
      if (!v.wr) chk({nm, "_rdata"}, rd, v.rd);
      chk({nm, "_valid_at_ack"}, mv, 1'b0);
      @(posedge clk); @(negedge clk);
      chk({nm, "_release"}, {ack_oe_n, tmx_oe_n, ad_oe_n, busy}, 4'b1110);
    end
  endtask

  task automatic probe(input logic s_n, input logic a_n, input logic [31:0] a, input string nm);
    logic seen = 0;
    start_n = s_n; ack_n = a_n; tm1_n = 1; tm0_n = 1; ad_n = ~a;
    @(posedge clk); @(negedge clk);
    start_n = 1; ack_n = 1; ad_n = '1;
    for (int k = 0; k < 6; k++) begin
      if (mem_valid || busy || !ack_oe_n || !ad_oe_n || !tmx_oe_n) seen = 1;
      @(posedge clk); @(negedge clk);
    end
    chk({nm, "_ignored"}, seen, 1'b0);
  endtask

  initial begin
    //            wr tm0 addr          wdata         dly err req be     addr   status        rdata         lat
    vecs[0]  = '{1, 0, 32'hFC000003, 32'h87654321, 0, 0, 1, 4'hF, 22'd0, TMN_COMPLETE, 32'h0,        3};
    vecs[1]  = '{0, 0, 32'hFC000003, 32'h0,        0, 0, 1, 4'hF, 22'd0, TMN_COMPLETE, 32'h87654321, 2};
    vecs[2]  = '{1, 0, 32'hFC00000A, 32'hABCD0000, 0, 0, 1, 4'hC, 22'd2, TMN_COMPLETE, 32'h0,        3};
    vecs[3]  = '{1, 1, 32'hFC000016, 32'h00EE0000, 0, 0, 1, 4'h4, 22'd5, TMN_COMPLETE, 32'h0,        3};
    vecs[4]  = '{0, 0, 32'hFC00000A, 32'h0,        0, 0, 1, 4'hC, 22'd2, TMN_COMPLETE, 32'hABCD0000, 2};
    vecs[5]  = '{0, 1, 32'hFC000016, 32'h0,        0, 0, 1, 4'h4, 22'd5, TMN_COMPLETE, 32'h00EE0000, 2};
    vecs[6]  = '{1, 0, 32'hFC000010, 32'h00001234, 0, 0, 1, 4'h3, 22'd4, TMN_COMPLETE, 32'h0,        3};
    vecs[7]  = '{0, 0, 32'hFC000013, 32'h0,        0, 0, 1, 4'hF, 22'd4, TMN_COMPLETE, 32'h00001234, 2};
    vecs[8]  = '{0, 0, 32'hFC000001, 32'h0,        0, 0, 0, 4'h0, 22'd0, TMN_ERROR,    32'h0,        2};
    vecs[9]  = '{1, 0, 32'hFC000021, 32'h55,       0, 0, 0, 4'h0, 22'd0, TMN_ERROR,    32'h0,        2};
    vecs[10] = '{0, 0, 32'hFC000003, 32'h0,        3, 0, 1, 4'hF, 22'd0, TMN_COMPLETE, 32'h87654321, 5};
    vecs[11] = '{0, 0, 32'hFC000003, 32'h0,        0, 1, 1, 4'hF, 22'd0, TMN_ERROR,    32'h0,        2};
    vecs[12] = '{1, 0, 32'hFC00001F, 32'hDEADBEEF, 2, 0, 1, 4'hF, 22'd7, TMN_COMPLETE, 32'h0,        5};
    vecs[13] = '{0, 0, 32'hFC00001F, 32'h0,        0, 0, 1, 4'hF, 22'd7, TMN_COMPLETE, 32'hDEADBEEF, 2};
    vecs[14] = '{0, 1, 32'hFC000005, 32'h0,        0, 0, 1, 4'h2, 22'd1, TMN_COMPLETE, 32'h0,        2};
    vecs[15] = '{1, 0, 32'hFC000007, 32'h11111111, 0, 1, 1, 4'hF, 22'd1, TMN_ERROR,    32'h0,        3};
    vecs[16] = '{0, 0, 32'hFC00000B, 32'h0,       -1, 0, 1, 4'hF, 22'd2, TMN_ERROR,    32'h0,      201};
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    probe(0, 1, 32'hFD000003, "other_slot");
    probe(0, 0, 32'hFC000003, "attention");
    // Reset while a read waits in REQ
    rdy_dly = -1; err_flag = 0;
    sb.push_back(req_t'{1'b0, 22'd12, 4'hF, 32'h0});
    start_n = 0; tm1_n = 1; tm0_n = 1; ad_n = ~32'hFC000033;
    @(posedge clk); @(negedge clk);
    start_n = 1; ad_n = '1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("mid_req_valid", {mem_valid, busy}, 2'b11);
    reset_n = 0;
    @(posedge clk); @(negedge clk);
    check_reset("mid_reset");
    reset_n = 1;
    run_vec('{0, 0, 32'hFC000003, 32'h0, 0, 0, 1, 4'hF, 22'd0, TMN_COMPLETE, 32'h87654321, 2}, "post_reset");
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
